// File: rtl/multi_crop_stream.sv
// multi_crop_stream: single-pass raster cropper fanning each pixel out to NUM_CROPS clamped windows
module multi_crop_stream #(
   parameter int PIXEL_BIT_WIDTH = 16,
   parameter int IN_ROWS = 100,
   parameter int IN_COLS = 160,
   parameter int OUT_ROWS = 48,
   parameter int OUT_COLS = 48,
   parameter int NUM_CROPS = 5,
   localparam int RW = $clog2(IN_ROWS),
   localparam int CW = $clog2(IN_COLS)
) (
   input  logic                               ap_clk,
   input  logic                               ap_rst_n,
   input  logic                               ap_start,
   output logic                               ap_done,
   output logic                               ap_idle,
   output logic                               ap_ready,
   input  logic [NUM_CROPS*RW-1:0]            crop_y,
   input  logic [NUM_CROPS*CW-1:0]            crop_x,
   input  logic [PIXEL_BIT_WIDTH-1:0]         crop_input_TDATA,
   input  logic                               crop_input_TVALID,
   output logic                               crop_input_TREADY,
   output logic [NUM_CROPS*PIXEL_BIT_WIDTH-1:0] crop_output_TDATA,
   output logic [NUM_CROPS-1:0]               crop_output_TVALID,
   input  logic [NUM_CROPS-1:0]               crop_output_TREADY,
   output logic [NUM_CROPS-1:0]               crop_output_TLAST
);
   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
   localparam logic [RW-1:0] Y_MAX = RW'(IN_ROWS - OUT_ROWS);
   localparam logic [CW-1:0] X_MAX = CW'(IN_COLS - OUT_COLS);
   localparam logic [RW:0] OR_N = (RW+1)'(OUT_ROWS);
   localparam logic [RW:0] OR_M1 = (RW+1)'(OUT_ROWS - 1);
   localparam logic [CW:0] OC_N = (CW+1)'(OUT_COLS);
   localparam logic [CW:0] OC_M1 = (CW+1)'(OUT_COLS - 1);
   state_t                     state_q;
   logic [RW-1:0]              row_q;
   logic [CW-1:0]              col_q;
   logic [RW-1:0]              y_q [NUM_CROPS];
   logic [CW-1:0]              x_q [NUM_CROPS];
   logic [PIXEL_BIT_WIDTH-1:0] dat_q [NUM_CROPS];
   logic [NUM_CROPS-1:0]       vld_q, lst_q, hit, last_hit;
   logic                       acc, col_wrap, frame_end;
   // Window membership of the current raster position, with one extra bit so window ends never wrap
   always_comb begin
      hit = '0;
      last_hit = '0;
      for (int k = 0; k < NUM_CROPS; k++) begin
         hit[k] = row_q >= y_q[k] && {1'b0, row_q} < {1'b0, y_q[k]} + OR_N &&
                  col_q >= x_q[k] && {1'b0, col_q} < {1'b0, x_q[k]} + OC_N;
         last_hit[k] = {1'b0, row_q} == {1'b0, y_q[k]} + OR_M1 &&
                       {1'b0, col_q} == {1'b0, x_q[k]} + OC_M1;
      end
   end
   assign crop_input_TREADY = state_q == RUN && &(~hit | ~vld_q | crop_output_TREADY);
   assign acc = crop_input_TVALID && crop_input_TREADY;
   assign col_wrap = col_q == CW'(IN_COLS - 1);
   assign frame_end = col_wrap && row_q == RW'(IN_ROWS - 1);
   assign ap_idle = state_q == IDLE;
   assign ap_done = state_q == DONE;
   assign ap_ready = state_q == DONE;
   assign crop_output_TVALID = vld_q;
   assign crop_output_TLAST = lst_q & vld_q;
   for (genvar g = 0; g < NUM_CROPS; g++) begin : g_out
      assign crop_output_TDATA[g*PIXEL_BIT_WIDTH +: PIXEL_BIT_WIDTH] = dat_q[g];
   end
   // Frame control: latch clamped origins at start, walk the raster, wait for output drain
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q <= IDLE;
         row_q <= '0;
         col_q <= '0;
         for (int k = 0; k < NUM_CROPS; k++) begin
            y_q[k] <= '0;
            x_q[k] <= '0;
         end
      end else begin
         case (state_q)
            IDLE: if (ap_start) begin
               state_q <= RUN;
               row_q <= '0;
               col_q <= '0;
               for (int k = 0; k < NUM_CROPS; k++) begin
                  y_q[k] <= crop_y[k*RW +: RW] > Y_MAX ? Y_MAX : crop_y[k*RW +: RW];
                  x_q[k] <= crop_x[k*CW +: CW] > X_MAX ? X_MAX : crop_x[k*CW +: CW];
               end
            end
            RUN: if (acc) begin
               col_q <= col_wrap ? '0 : col_q + 1'b1;
               row_q <= col_wrap ? row_q + 1'b1 : row_q;
               state_q <= frame_end ? FLUSH : RUN;
            end
            FLUSH: state_q <= ~|(vld_q & ~crop_output_TREADY) ? DONE : FLUSH;
            DONE: state_q <= IDLE;
         endcase
      end
   end
   // Per-channel output register: reload on a hitting handshake, otherwise empty on drain
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         vld_q <= '0;
         lst_q <= '0;
         for (int k = 0; k < NUM_CROPS; k++) dat_q[k] <= '0;
      end else begin
         for (int k = 0; k < NUM_CROPS; k++) begin
            if (acc && hit[k]) begin
               vld_q[k] <= 1'b1;
               lst_q[k] <= last_hit[k];
               dat_q[k] <= crop_input_TDATA;
            end else if (crop_output_TREADY[k]) begin
               vld_q[k] <= 1'b0;
            end
         end
      end
   end
endmodule

// File: tb/tb_multi_crop_stream.sv
// tb_multi_crop_stream: directed frames against a per-channel window model of the cropper
module tb_multi_crop_stream;
   localparam int NC = 5, PW = 16, RW = 7, CW = 8, N = 16000, CL = 2304;
   logic ap_clk = 0, ap_rst_n = 0, ap_start = 0;
   logic ap_done, ap_idle, ap_ready;
   logic [NC*RW-1:0] crop_y = '0;
   logic [NC*CW-1:0] crop_x = '0;
   logic [PW-1:0] crop_input_TDATA = '0;
   logic crop_input_TVALID = 0, crop_input_TREADY;
   logic [NC*PW-1:0] crop_output_TDATA;
   logic [NC-1:0] crop_output_TVALID, crop_output_TLAST;
   logic [NC-1:0] crop_output_TREADY = '0;
   int checks = 0, failures = 0;
   int ry[NC], rx[NC], oy[NC], ox[NC];
   int got_n[NC], bad[NC], first_v[NC], last_v[NC], pushed[NC], held_d[NC];
   logic [NC-1:0] held;
   int ptr, cyc, done_n, ready_n, done_cyc, rdy_bad, stab_bad, stall;

   multi_crop_stream #(.PIXEL_BIT_WIDTH(PW), .IN_ROWS(100), .IN_COLS(160), .OUT_ROWS(48),
                       .OUT_COLS(48), .NUM_CROPS(NC)) dut (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_done(ap_done),
      .ap_idle(ap_idle), .ap_ready(ap_ready), .crop_y(crop_y), .crop_x(crop_x),
      .crop_input_TDATA(crop_input_TDATA), .crop_input_TVALID(crop_input_TVALID),
      .crop_input_TREADY(crop_input_TREADY), .crop_output_TDATA(crop_output_TDATA),
      .crop_output_TVALID(crop_output_TVALID), .crop_output_TREADY(crop_output_TREADY),
      .crop_output_TLAST(crop_output_TLAST));

   always #5 ap_clk = ~ap_clk;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic bit hits(int k, int p);
      int r = p / 160, c = p % 160;
      return r >= oy[k] && r < oy[k] + 48 && c >= ox[k] && c < ox[k] + 48;
   endfunction

   function automatic int ref_px(int k, int i);
      return (oy[k] + i / 48) * 160 + ox[k] + i % 48;
   endfunction

   task automatic sample();
      logic exp_rdy;
      int d;
      exp_rdy = ptr < N;
      for (int k = 0; k < NC; k++)
         if (ptr < N && hits(k, ptr) && pushed[k] != got_n[k] && !crop_output_TREADY[k]) exp_rdy = 0;
      if (crop_input_TREADY !== exp_rdy) rdy_bad++;
      if (ap_done) begin done_n++; done_cyc = cyc; end
      if (ap_ready) ready_n++;
      for (int k = 0; k < NC; k++) begin
         d = int'(crop_output_TDATA[k*PW +: PW]);
         if (held[k] && (!crop_output_TVALID[k] || d != held_d[k])) stab_bad++;
         held[k] = 0;
         if (crop_output_TVALID[k]) begin
            if (crop_output_TREADY[k]) begin
               if (d != ref_px(k, got_n[k]) || crop_output_TLAST[k] !== (got_n[k] == CL - 1)) bad[k]++;
               if (got_n[k] == 0) first_v[k] = d;
               if (crop_output_TLAST[k]) last_v[k] = d;
               got_n[k]++;
            end else begin
               held[k] = 1;
               held_d[k] = d;
            end
         end
      end
      if (crop_input_TVALID && crop_input_TREADY) begin
         for (int k = 0; k < NC; k++) if (hits(k, ptr)) pushed[k]++;
         ptr++;
      end
   endtask

   // mode 0: all ready, 1: channel 2 stalled 100 cycles mid-crop, 2: random valid/ready + stray start
   task automatic run_frame(input int mode, input int abort_p);
      for (int k = 0; k < NC; k++) begin
         oy[k] = ry[k] > 52 ? 52 : ry[k];
         ox[k] = rx[k] > 112 ? 112 : rx[k];
         got_n[k] = 0; bad[k] = 0; first_v[k] = -1; last_v[k] = -1; pushed[k] = 0;
      end
      held = '0;
      ptr = 0; cyc = 0; done_n = 0; ready_n = 0; done_cyc = 0; rdy_bad = 0; stab_bad = 0; stall = 0;
      @(negedge ap_clk);
      for (int k = 0; k < NC; k++) begin
         crop_y[k*RW +: RW] = RW'(ry[k]);
         crop_x[k*CW +: CW] = CW'(rx[k]);
      end
      ap_start = 1;
      while (done_n == 0 && ptr < abort_p && cyc < 40000) begin
         @(negedge ap_clk);
         cyc++;
         ap_start = mode == 2 && cyc == 50;
         crop_input_TDATA = ptr < N ? PW'(ptr) : '0;
         crop_input_TVALID = ptr < N && (mode != 2 || $urandom_range(3) != 0);
         for (int k = 0; k < NC; k++)
            crop_output_TREADY[k] = mode == 2 ? $urandom_range(3) != 0 :
                                    !(mode == 1 && k == 2 && stall > 0 && stall <= 100);
         #1 sample();
         if (mode == 1 && got_n[2] >= 1000 && stall <= 100) stall++;
      end
      check("frame_bounded", int'(cyc < 40000), 1);
   endtask

   task automatic frame_checks(input string name, input bit timed);
      check({name, "_done_pulses"}, done_n, 1);
      check({name, "_ready_pulses"}, ready_n, 1);
      check({name, "_in_ready_model"}, rdy_bad, 0);
      check({name, "_hold_stable"}, stab_bad, 0);
      if (timed) check({name, "_done_cycle"}, done_cyc, N + 2);
      for (int k = 0; k < NC; k++) begin
         check($sformatf("%s_ch%0d_count", name, k), got_n[k], CL);
         check($sformatf("%s_ch%0d_data", name, k), bad[k], 0);
         check($sformatf("%s_ch%0d_last", name, k), last_v[k], ref_px(k, CL - 1));
      end
      @(negedge ap_clk);
      #1;
      check({name, "_idle_after"}, int'(ap_idle), 1);
      check({name, "_done_clear"}, int'(ap_done), 0);
   endtask

   initial begin
      repeat (3) @(negedge ap_clk);
      check("rst_idle", int'(ap_idle), 1);
      check("rst_done", int'(ap_done), 0);
      check("rst_ready", int'(ap_ready), 0);
      check("rst_in_ready", int'(crop_input_TREADY), 0);
      check("rst_valid", int'(crop_output_TVALID), 0);
      check("rst_data", int'(crop_output_TDATA != 0), 0);
      ap_rst_n = 1;

      for (int k = 0; k < NC; k++) begin ry[k] = 10; rx[k] = 10; end
      run_frame(0, N + 1);
      frame_checks("same10", 1);
      for (int k = 0; k < NC; k++) check($sformatf("same10_ch%0d_first", k), first_v[k], 1610);
      check("same10_ch0_last_abs", last_v[0], 9177);

      ry = '{0, 52, 60, 99, 20}; rx = '{0, 112, 150, 159, 20};
      run_frame(1, N + 1);
      frame_checks("clamp_stall", 0);
      check("clamp_ch0_first", first_v[0], 0);
      check("clamp_ch1_last", last_v[1], 15999);
      check("clamp_ch2_first", first_v[2], 8432);
      check("clamp_ch3_first", first_v[3], 8432);
      check("clamp_ch4_first", first_v[4], 3220);
      check("stall_applied", stall, 101);

      ry = '{5, 30, 0, 40, 52}; rx = '{7, 100, 0, 60, 112};
      run_frame(2, N + 1);
      frame_checks("random", 0);

      run_frame(0, 30 * 160 + 20);
      ap_rst_n = 0;
      #1;
      check("abort_valid", int'(crop_output_TVALID), 0);
      check("abort_last", int'(crop_output_TLAST), 0);
      check("abort_data", int'(crop_output_TDATA != 0), 0);
      check("abort_idle", int'(ap_idle), 1);
      check("abort_in_ready", int'(crop_input_TREADY), 0);
      check("abort_no_done", done_n, 0);
      @(negedge ap_clk);
      ap_rst_n = 1;

      ry = '{1, 3, 50, 51, 52}; rx = '{2, 4, 100, 111, 112};
      run_frame(0, N + 1);
      frame_checks("after_reset", 1);
      check("after_reset_ch1_first", first_v[1], 484);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
